// File: rtl/vliw_scoreboard_if.sv
// vliw_scoreboard_if: issue-side bundle between a VLIW decoder and the
// register scoreboard.
//   issue_valid/issue_ready : packet handshake (ready is combinational)
//   dst_idx/dst_vld         : 8 x 5-bit destinations; slot order is add0, add1,
//                             mul hi, mul lo, fadd0, fadd1, fmul, logic
//   src_idx/src_vld         : 15 x 5-bit sources (14 ALU operands + store data)
//   flush                   : drop all pending-write tracking
//   busy_mask               : per-register pending-write flags (registered)
//   dup_dest                : pulse, accepted packet named one register twice
//   stall_cnt               : stalled-cycle counter (0 unless stats are built)
interface vliw_scoreboard_if;
  logic        issue_valid;
  logic        issue_ready;
  logic [39:0] dst_idx;
  logic [7:0]  dst_vld;
  logic [74:0] src_idx;
  logic [14:0] src_vld;
  logic        flush;
  logic [31:0] busy_mask;
  logic        dup_dest;
  logic [31:0] stall_cnt;

  modport master (
    output issue_valid, dst_idx, dst_vld, src_idx, src_vld, flush,
    input  issue_ready, busy_mask, dup_dest, stall_cnt
  );

  modport slave (
    input  issue_valid, dst_idx, dst_vld, src_idx, src_vld, flush,
    output issue_ready, busy_mask, dup_dest, stall_cnt
  );
endinterface

// File: rtl/vliw_scoreboard.sv
// vliw_scoreboard: pending-write tracker for a VLIW issue stage.
// One 4-bit countdown per architectural register 1..31 (r0 is hardwired and
// never tracked). A packet may issue only when none of its valid sources or
// destinations has a nonzero countdown; on issue each destination loads the
// latency of the unit writing it, and counters tick down once per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   sb         : vliw_scoreboard_if.slave (see interface header)
// Parameters LAT_* are issue-to-visible latencies and must lie in 1..15.
// Optional feature: define SCOREBOARD_STATS_EN to build the saturating
// stall-cycle counter; otherwise stall_cnt is tied to 0.

// Per-register countdown. busy is its own flop, loaded from the next counter
// value, so it always equals (cnt != 0) without a decode after the register.
module vliw_sb_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       ld,
  input  logic [3:0] ld_val,
  output logic [3:0] cnt,
  output logic       busy
);
  logic [3:0] cnt_nxt;

  // Load wins over the decrement, so a register reaching zero and being
  // re-targeted on the same edge ends up holding the new latency.
  always_comb begin
    cnt_nxt = cnt;
    if (flush)             cnt_nxt = '0;
    else if (ld)           cnt_nxt = ld_val;
    else if (cnt != 4'd0)  cnt_nxt = cnt - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      busy <= (cnt_nxt != 4'd0);
    end
  end
endmodule

module vliw_scoreboard #(
  parameter int LAT_ADD   = 4,
  parameter int LAT_MUL   = 13,
  parameter int LAT_FADD  = 3,
  parameter int LAT_FMUL  = 13,
  parameter int LAT_LOGIC = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  vliw_scoreboard_if.slave sb
);
  localparam int NUM_REGS = 32;
  localparam int NUM_DST  = 8;
  localparam int NUM_SRC  = 15;
  localparam int IDX_W    = 5;

  function automatic logic [3:0] slot_lat(input int s);
    case (s)
      0, 1:    slot_lat = 4'(LAT_ADD);
      2, 3:    slot_lat = 4'(LAT_MUL);
      4, 5:    slot_lat = 4'(LAT_FADD);
      6:       slot_lat = 4'(LAT_FMUL);
      default: slot_lat = 4'(LAT_LOGIC);
    endcase
  endfunction

  logic [NUM_REGS-1:0][3:0] cnt;
  logic [NUM_REGS-1:0]      busy;
  logic                     hazard;
  logic                     dup;
  logic                     accept;

  assign cnt[0]  = '0;
  assign busy[0] = 1'b0;

  // Any valid operand (r0 excluded) with a live countdown blocks issue;
  // a count of 1 still means the value is not yet visible.
  always_comb begin
    logic [IDX_W-1:0] idx;
    hazard = 1'b0;
    for (int s = 0; s < NUM_DST; s++) begin
      idx = sb.dst_idx[s*IDX_W +: IDX_W];
      if (sb.dst_vld[s] && idx != '0 && cnt[idx] != 4'd0) hazard = 1'b1;
    end
    for (int j = 0; j < NUM_SRC; j++) begin
      idx = sb.src_idx[j*IDX_W +: IDX_W];
      if (sb.src_vld[j] && idx != '0 && cnt[idx] != 4'd0) hazard = 1'b1;
    end
  end

  // Two valid slots naming the same real register; r0 writes are discarded
  // so collisions there are harmless and not reported.
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < NUM_DST; i++)
      for (int k = i + 1; k < NUM_DST; k++)
        if (sb.dst_vld[i] && sb.dst_vld[k] &&
            sb.dst_idx[i*IDX_W +: IDX_W] == sb.dst_idx[k*IDX_W +: IDX_W] &&
            sb.dst_idx[i*IDX_W +: IDX_W] != '0)
          dup = 1'b1;
  end

  assign sb.issue_ready = !hazard && !sb.flush;
  assign accept         = sb.issue_valid && sb.issue_ready;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    logic       ld;
    logic [3:0] ld_val;

    // Duplicate writers load the longest latency so the register stays busy
    // until the last producer lands.
    always_comb begin
      ld     = 1'b0;
      ld_val = '0;
      for (int s = 0; s < NUM_DST; s++)
        if (accept && sb.dst_vld[s] &&
            sb.dst_idx[s*IDX_W +: IDX_W] == IDX_W'(r)) begin
          ld = 1'b1;
          if (slot_lat(s) > ld_val) ld_val = slot_lat(s);
        end
    end

    vliw_sb_cnt u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush  (sb.flush),
      .ld     (ld),
      .ld_val (ld_val),
      .cnt    (cnt[r]),
      .busy   (busy[r])
    );
  end

  assign sb.busy_mask = busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        sb.dup_dest <= 1'b0;
    else if (sb.flush) sb.dup_dest <= 1'b0;
    else               sb.dup_dest <= accept && dup;
  end

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_q <= '0;
    else if (sb.issue_valid && !sb.issue_ready && stall_q != '1)
      stall_q <= stall_q + 32'd1;
  end

  assign sb.stall_cnt = stall_q;
`else
  assign sb.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_vliw_scoreboard.sv
module tb_vliw_scoreboard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

`ifdef SCOREBOARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  vliw_scoreboard_if sbif ();

  vliw_scoreboard dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sbif)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pkt;
    sbif.issue_valid = 1'b0;
    sbif.dst_idx     = '0;
    sbif.dst_vld     = '0;
    sbif.src_idx     = '0;
    sbif.src_vld     = '0;
  endtask

  task automatic set_dst(input int s, input logic [4:0] r);
    sbif.dst_idx[s*5 +: 5] = r;
    sbif.dst_vld[s]        = 1'b1;
  endtask

  task automatic set_src(input int j, input logic [4:0] r);
    sbif.src_idx[j*5 +: 5] = r;
    sbif.src_vld[j]        = 1'b1;
  endtask

  task automatic reset_dut;
    clr_pkt();
    sbif.flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    clr_pkt();
    sbif.flush = 1'b0;
    #3;
    checks++; if (sbif.busy_mask !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h want 0", sbif.busy_mask); end
    checks++; if (sbif.dup_dest !== 1'b0) begin errors++; $display("FAIL reset_dup: got %b want 0", sbif.dup_dest); end
    checks++; if (sbif.stall_cnt !== 32'h0) begin errors++; $display("FAIL reset_stall: got %h want 0", sbif.stall_cnt); end
    checks++; if (sbif.issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", sbif.issue_ready); end
    rst_n = 1'b1;
    tick();
    // issue_valid low: a packet naming r12 must leave nothing behind
    set_dst(0, 5'd12);
    tick();
    tick();
    checks++; if (sbif.busy_mask !== 32'h0) begin errors++; $display("FAIL idle_no_load: got %h want 0", sbif.busy_mask); end
    clr_pkt();
  endtask

  task automatic test_raw;
    int n;
    reset_dut();
    set_dst(0, 5'd5);
    sbif.issue_valid = 1'b1;
    #1;
    checks++; if (sbif.issue_ready !== 1'b1) begin errors++; $display("FAIL raw_first_ready: got %b want 1", sbif.issue_ready); end
    tick();
    clr_pkt();
    set_src(0, 5'd5);
    sbif.issue_valid = 1'b1;
    #1;
    checks++; if (sbif.busy_mask !== 32'h20) begin errors++; $display("FAIL raw_busy: got %h want 20", sbif.busy_mask); end
    n = 0;
    while (!sbif.issue_ready && n < 40) begin
      checks++; if (sbif.busy_mask[5] !== 1'b1) begin errors++; $display("FAIL raw_busy_hold: got %b want 1 at %0d", sbif.busy_mask[5], n); end
      n++;
      tick();
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL raw_stall_len: got %0d want 4", n); end
    checks++; if (sbif.busy_mask[5] !== 1'b0) begin errors++; $display("FAIL raw_busy_clear: got %b want 0", sbif.busy_mask[5]); end
    tick();
    clr_pkt();
  endtask

  task automatic test_waw;
    int n;
    reset_dut();
    set_dst(2, 5'd2);
    set_dst(3, 5'd3);
    sbif.issue_valid = 1'b1;
    tick();
    clr_pkt();
    set_dst(0, 5'd3);
    sbif.issue_valid = 1'b1;
    #1;
    checks++; if (sbif.busy_mask !== 32'h0C) begin errors++; $display("FAIL waw_busy: got %h want 0c", sbif.busy_mask); end
    n = 0;
    while (!sbif.issue_ready && n < 40) begin
      n++;
      tick();
    end
    checks++; if (n !== 13) begin errors++; $display("FAIL waw_stall_len: got %0d want 13", n); end
    checks++; if (sbif.stall_cnt !== (STATS ? 32'd13 : 32'd0)) begin errors++; $display("FAIL waw_stall_cnt: got %0d want %0d", sbif.stall_cnt, STATS ? 13 : 0); end
    tick();
    clr_pkt();
    checks++; if (sbif.busy_mask !== 32'h08) begin errors++; $display("FAIL waw_reload: got %h want 08", sbif.busy_mask); end
  endtask

  task automatic test_r0;
    reset_dut();
    for (int s = 0; s < 8; s++) set_dst(s, 5'd0);
    for (int j = 0; j < 15; j++) set_src(j, 5'd0);
    sbif.issue_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (sbif.issue_ready !== 1'b1) begin errors++; $display("FAIL r0_ready: got %b want 1 at %0d", sbif.issue_ready, c); end
      checks++; if (sbif.busy_mask !== 32'h0) begin errors++; $display("FAIL r0_busy: got %h want 0 at %0d", sbif.busy_mask, c); end
      tick();
    end
    clr_pkt();
  endtask

  task automatic test_back_to_back;
    reset_dut();
    set_dst(0, 5'd1);
    set_dst(3, 5'd8);
    set_dst(5, 5'd6);
    set_dst(7, 5'd4);
    sbif.issue_valid = 1'b1;
    tick();
    clr_pkt();
    checks++; if (sbif.busy_mask !== 32'h152) begin errors++; $display("FAIL b2b_e0: got %h want 152", sbif.busy_mask); end
    set_dst(1, 5'd10);
    set_src(0, 5'd11);
    sbif.issue_valid = 1'b1;
    #1;
    checks++; if (sbif.issue_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", sbif.issue_ready); end
    tick();
    clr_pkt();
    checks++; if (sbif.busy_mask !== 32'h542) begin errors++; $display("FAIL b2b_e1: got %h want 542", sbif.busy_mask); end
    checks++; if (sbif.dup_dest !== 1'b0) begin errors++; $display("FAIL b2b_nodup: got %b want 0", sbif.dup_dest); end
    tick();
    checks++; if (sbif.busy_mask !== 32'h542) begin errors++; $display("FAIL b2b_e2: got %h want 542", sbif.busy_mask); end
    tick();
    checks++; if (sbif.busy_mask !== 32'h502) begin errors++; $display("FAIL b2b_e3: got %h want 502", sbif.busy_mask); end
    tick();
    checks++; if (sbif.busy_mask !== 32'h500) begin errors++; $display("FAIL b2b_e4: got %h want 500", sbif.busy_mask); end
    tick();
    checks++; if (sbif.busy_mask !== 32'h100) begin errors++; $display("FAIL b2b_e5: got %h want 100", sbif.busy_mask); end
    // store-data source (last src slot) on a still-busy register
    set_src(14, 5'd8);
    sbif.issue_valid = 1'b1;
    #1;
    checks++; if (sbif.issue_ready !== 1'b0) begin errors++; $display("FAIL b2b_src14: got %b want 0", sbif.issue_ready); end
    clr_pkt();
  endtask

  task automatic test_dup;
    int n;
    reset_dut();
    set_dst(4, 5'd7);
    set_dst(6, 5'd7);
    sbif.issue_valid = 1'b1;
    tick();
    clr_pkt();
    checks++; if (sbif.dup_dest !== 1'b1) begin errors++; $display("FAIL dup_pulse: got %b want 1", sbif.dup_dest); end
    checks++; if (sbif.busy_mask !== 32'h80) begin errors++; $display("FAIL dup_busy: got %h want 80", sbif.busy_mask); end
    tick();
    checks++; if (sbif.dup_dest !== 1'b0) begin errors++; $display("FAIL dup_one_cycle: got %b want 0", sbif.dup_dest); end
    n = 1;
    while (sbif.busy_mask[7] && n < 40) begin
      n++;
      tick();
    end
    checks++; if (n !== 13) begin errors++; $display("FAIL dup_busy_len: got %0d want 13", n); end
  endtask

  task automatic test_flush;
    reset_dut();
    set_dst(6, 5'd9);
    sbif.issue_valid = 1'b1;
    tick();
    clr_pkt();
    repeat (4) tick();
    checks++; if (sbif.busy_mask !== 32'h200) begin errors++; $display("FAIL flush_pre: got %h want 200", sbif.busy_mask); end
    sbif.flush = 1'b1;
    set_src(0, 5'd9);
    sbif.issue_valid = 1'b1;
    #1;
    checks++; if (sbif.issue_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", sbif.issue_ready); end
    tick();
    sbif.flush = 1'b0;
    #1;
    checks++; if (sbif.busy_mask !== 32'h0) begin errors++; $display("FAIL flush_busy: got %h want 0", sbif.busy_mask); end
    checks++; if (sbif.issue_ready !== 1'b1) begin errors++; $display("FAIL flush_after_ready: got %b want 1", sbif.issue_ready); end
    tick();
    clr_pkt();
  endtask

  task automatic test_reset_mid;
    reset_dut();
    set_dst(6, 5'd9);
    sbif.issue_valid = 1'b1;
    tick();
    clr_pkt();
    set_src(0, 5'd9);
    sbif.issue_valid = 1'b1;
    repeat (5) tick();
    checks++; if (sbif.stall_cnt !== (STATS ? 32'd5 : 32'd0)) begin errors++; $display("FAIL mid_stall_pre: got %0d want %0d", sbif.stall_cnt, STATS ? 5 : 0); end
    checks++; if (sbif.busy_mask !== 32'h200) begin errors++; $display("FAIL mid_busy_pre: got %h want 200", sbif.busy_mask); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (sbif.busy_mask !== 32'h0) begin errors++; $display("FAIL mid_busy: got %h want 0", sbif.busy_mask); end
    checks++; if (sbif.stall_cnt !== 32'h0) begin errors++; $display("FAIL mid_stall: got %h want 0", sbif.stall_cnt); end
    checks++; if (sbif.issue_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", sbif.issue_ready); end
    #3;
    rst_n = 1'b1;
    tick();
    checks++; if (sbif.busy_mask !== 32'h0) begin errors++; $display("FAIL mid_after: got %h want 0", sbif.busy_mask); end
    clr_pkt();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_waw();
    test_r0();
    test_back_to_back();
    test_dup();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
